// File: rtl/cam_pixel_reader_pkg.sv
// Shared definitions for the camera pixel reader: FSM encoding, FIFO entry
// layout and RGB565 field widths.
package cam_pkg;

   localparam int FIFO_W  = 9;
   localparam int SOF_BIT = 8;
   localparam int BYTE_W  = 8;

   localparam int R_W  = 5;
   localparam int G_W  = 6;
   localparam int B_W  = 5;
   localparam int PX_W = R_W + G_W + B_W;

   localparam logic [1:0] ST_SEEK = 2'd0;
   localparam logic [1:0] ST_HI   = 2'd1;
   localparam logic [1:0] ST_LO   = 2'd2;

   typedef struct packed {
      logic [R_W-1:0] r;
      logic [G_W-1:0] g;
      logic [B_W-1:0] b;
   } rgb565_t;

   // The camera sends the high byte first; the pixel is the plain concatenation.
   function automatic logic [PX_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                  input logic [BYTE_W-1:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/cam_pixel_reader_if.sv
// Capture-FIFO and frame-buffer signal bundle for cam_pixel_reader.
// err_count exists only when CAM_ERRCNT_EN is defined.
interface cam_pixel_reader_if #(
   parameter int ADDR_W = 15
);
   import cam_pkg::*;

   logic              fifo_empty;
   logic              fifo_rd;
   logic [FIFO_W-1:0] fifo_dout;
   logic              px_valid;
   logic [PX_W-1:0]   px_data;
   logic [ADDR_W-1:0] px_addr;
   logic              frame_done;
   logic              sync_err;
`ifdef CAM_ERRCNT_EN
   logic [7:0]        err_count;
`endif

`ifdef CAM_ERRCNT_EN
   modport master (
      input  fifo_empty, fifo_dout,
      output fifo_rd, px_valid, px_data, px_addr, frame_done, sync_err, err_count
   );
   modport slave (
      output fifo_empty, fifo_dout,
      input  fifo_rd, px_valid, px_data, px_addr, frame_done, sync_err, err_count
   );
`else
   modport master (
      input  fifo_empty, fifo_dout,
      output fifo_rd, px_valid, px_data, px_addr, frame_done, sync_err
   );
   modport slave (
      output fifo_empty, fifo_dout,
      input  fifo_rd, px_valid, px_data, px_addr, frame_done, sync_err
   );
`endif

endinterface

// File: rtl/cam_pixel_reader_addr_gen.sv
// Frame-buffer address counter: clears on frame start, advances per pixel and
// wraps to zero after the last pixel of the frame.
module pix_addr_gen #(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 120,
   parameter int ADDR_W   = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] addr,
   output logic              last
);

   localparam int               N_PIX     = H_PIXELS * V_LINES;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

   logic [ADDR_W-1:0] addr_q, addr_d;

   assign last = (addr_q == LAST_ADDR);
   assign addr = addr_q;

   always_comb begin
      addr_d = addr_q;
      if (clr) begin
         addr_d = '0;
      end else if (adv) begin
         addr_d = last ? '0 : addr_q + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q <= '0;
      end else begin
         addr_q <= addr_d;
      end
   end

endmodule

// File: rtl/cam_pixel_reader.sv
// Rebuilds RGB565 pixels from the capture FIFO byte stream, aligned on the SOF
// marker, and generates frame-buffer addresses. CAM_ERRCNT_EN adds err_count.
//
//   state | meaning
//   SEEK  | waiting for an SOF-marked byte; unmarked bytes dropped
//   HI    | next consumed byte is the pixel high byte
//   LO    | next consumed byte completes the pixel
module cam_pixel_reader
   import cam_pkg::*;
#(
   parameter int H_PIXELS = 160,
   parameter int V_LINES  = 120,
   parameter int ADDR_W   = 15
) (
   input  logic                clock,
   input  logic                reset,
   cam_pixel_reader_if.master  cam
);

   logic [1:0]        state_q, state_d;
   logic              rd_q;
   logic [BYTE_W-1:0] hi_q, hi_d;
   logic              px_valid_q, px_valid_d;
   logic [PX_W-1:0]   px_data_q, px_data_d;
   logic [ADDR_W-1:0] px_addr_q, px_addr_d;
   logic              frame_done_q, frame_done_d;
   logic              sync_err_q, sync_err_d;

   logic              addr_clr, addr_adv, addr_last;
   logic [ADDR_W-1:0] addr_cur;
   logic              sof_in;
   logic [BYTE_W-1:0] rx_byte;

   assign cam.fifo_rd = !cam.fifo_empty && !reset;
   assign sof_in      = cam.fifo_dout[SOF_BIT];
   assign rx_byte     = cam.fifo_dout[BYTE_W-1:0];

   pix_addr_gen #(
      .H_PIXELS (H_PIXELS),
      .V_LINES  (V_LINES),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .clock (clock),
      .reset (reset),
      .clr   (addr_clr),
      .adv   (addr_adv),
      .addr  (addr_cur),
      .last  (addr_last)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      px_valid_d   = 1'b0;
      px_data_d    = px_data_q;
      px_addr_d    = px_addr_q;
      frame_done_d = 1'b0;
      sync_err_d   = 1'b0;
      addr_clr     = 1'b0;
      addr_adv     = 1'b0;

      if (rd_q) begin
         if (sof_in) begin
            // A marker always restarts the frame; outside SEEK it is premature.
            sync_err_d = (state_q != ST_SEEK);
            hi_d       = rx_byte;
            addr_clr   = 1'b1;
            state_d    = ST_LO;
         end else begin
            case (state_q)
               ST_HI: begin
                  hi_d    = rx_byte;
                  state_d = ST_LO;
               end
               ST_LO: begin
                  px_valid_d = 1'b1;
                  px_data_d  = join_bytes(hi_q, rx_byte);
                  px_addr_d  = addr_cur;
                  addr_adv   = 1'b1;
                  if (addr_last) begin
                     frame_done_d = 1'b1;
                     state_d      = ST_SEEK;
                  end else begin
                     state_d = ST_HI;
                  end
               end
               default: begin
                  state_d = ST_SEEK;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_SEEK;
         rd_q         <= 1'b0;
         hi_q         <= '0;
         px_valid_q   <= 1'b0;
         px_data_q    <= '0;
         px_addr_q    <= '0;
         frame_done_q <= 1'b0;
         sync_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         rd_q         <= cam.fifo_rd;
         hi_q         <= hi_d;
         px_valid_q   <= px_valid_d;
         px_data_q    <= px_data_d;
         px_addr_q    <= px_addr_d;
         frame_done_q <= frame_done_d;
         sync_err_q   <= sync_err_d;
      end
   end

   assign cam.px_valid   = px_valid_q;
   assign cam.px_data    = px_data_q;
   assign cam.px_addr    = px_addr_q;
   assign cam.frame_done = frame_done_q;
   assign cam.sync_err   = sync_err_q;

`ifdef CAM_ERRCNT_EN
   logic [7:0] err_cnt_q, err_cnt_d;

   always_comb begin
      err_cnt_d = err_cnt_q;
      if (sync_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign cam.err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_cam_pixel_reader.sv
// Directed bench for cam_pixel_reader with a 4x2 frame; the err_count step runs
// only when CAM_ERRCNT_EN is defined.
module tb_cam_pixel_reader;
   import cam_pkg::*;

   typedef struct {
      logic [15:0] d;
      logic [14:0] a;
      logic        fd;
   } px_t;

   logic clock;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;
   int   serr_cnt = 0;
   int   fd_cnt = 0;
   px_t  log_q[$];
   logic [8:0] pend;

   cam_pixel_reader_if #(.ADDR_W(15)) cam ();

   cam_pixel_reader #(
      .H_PIXELS (4),
      .V_LINES  (2),
      .ADDR_W   (15)
   ) dut (
      .clock (clock),
      .reset (reset),
      .cam   (cam.master)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (cam.px_valid) log_q.push_back('{d: cam.px_data, a: cam.px_addr, fd: cam.frame_done});
      if (cam.sync_err) serr_cnt++;
      if (cam.frame_done) fd_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: present the byte popped last cycle, offer nxt if avail.
   task automatic cyc(input bit avail, input logic [8:0] nxt, input bit rst);
      @(negedge clock);
      cam.fifo_dout  = pend;
      cam.fifo_empty = !avail;
      reset          = rst;
      pend           = (avail && !rst) ? nxt : 9'h1AA;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 9'h0, 1'b0);
   endtask

   task automatic chk_px(input int idx, input logic [15:0] d, input logic [14:0] a, input logic fd);
      if (idx >= log_q.size()) begin
         chk("px_missing", log_q.size(), idx + 1);
      end else begin
         chk($sformatf("px%0d_data", idx), {16'h0, log_q[idx].d}, {16'h0, d});
         chk($sformatf("px%0d_addr", idx), {17'h0, log_q[idx].a}, {17'h0, a});
         chk($sformatf("px%0d_fd", idx), {31'h0, log_q[idx].fd}, {31'h0, fd});
      end
   endtask

   task automatic clear_log();
      log_q.delete();
      serr_cnt = 0;
      fd_cnt   = 0;
   endtask

   logic [8:0]  frame_b [16];
   logic [15:0] frame_px [8];

   initial begin
      frame_b  = '{9'h1A5, 9'h05A, 9'h001, 9'h002, 9'h013, 9'h024, 9'h035, 9'h046,
                   9'h057, 9'h068, 9'h079, 9'h08A, 9'h09B, 9'h0AC, 9'h0BD, 9'h0CE};
      frame_px = '{16'hA55A, 16'h0102, 16'h1324, 16'h3546,
                   16'h5768, 16'h798A, 16'h9BAC, 16'hBDCE};
      reset          = 1'b1;
      cam.fifo_empty = 1'b1;
      cam.fifo_dout  = 9'h0;
      pend           = 9'h1AA;

      // Reset release with FIFO empty
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b0);
      cyc(1'b0, 9'h0, 1'b0);
      #1;
      chk("rst_fifo_rd", {31'h0, cam.fifo_rd}, 0);
      chk("rst_px_valid", {31'h0, cam.px_valid}, 0);
      chk("rst_px_data", {16'h0, cam.px_data}, 0);
      chk("rst_px_addr", {17'h0, cam.px_addr}, 0);
      chk("rst_frame_done", {31'h0, cam.frame_done}, 0);
      chk("rst_sync_err", {31'h0, cam.sync_err}, 0);
      chk("rst_state", {30'h0, dut.state_q}, {30'h0, ST_SEEK});

      // Unmarked bytes discarded, then SOF pixel with exact latency
      clear_log();
      cyc(1'b1, 9'h011, 1'b0);
      #1 chk("pop_fifo_rd", {31'h0, cam.fifo_rd}, 1);
      cyc(1'b1, 9'h022, 1'b0);
      cyc(1'b1, 9'h1F8, 1'b0);
      cyc(1'b1, 9'h000, 1'b0);
      cyc(1'b0, 9'h0, 1'b0);
      #1 chk("sof_early_valid", {31'h0, cam.px_valid}, 0);
      @(negedge clock); #1;
      chk("sof_valid", {31'h0, cam.px_valid}, 1);
      chk("sof_data", {16'h0, cam.px_data}, 32'hF800);
      chk("sof_addr", {17'h0, cam.px_addr}, 0);
      idle(3);
      chk("sof_count", log_q.size(), 1);
      chk("sof_serr", serr_cnt, 0);

      // Full frame with a 3-cycle gap after byte 5
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b0);
      clear_log();
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, frame_b[i], 1'b0);
         if (i == 4) idle(3);
      end
      idle(4);
      chk("frame_count", log_q.size(), 8);
      for (int i = 0; i < 8; i++) chk_px(i, frame_px[i], 15'(i), (i == 7));
      chk("frame_fd_cnt", fd_cnt, 1);
      chk("frame_serr", serr_cnt, 0);
      chk("frame_state", {30'h0, dut.state_q}, {30'h0, ST_SEEK});

      // After frame end, unmarked bytes are ignored
      clear_log();
      cyc(1'b1, 9'h055, 1'b0);
      cyc(1'b1, 9'h066, 1'b0);
      idle(4);
      chk("post_frame_count", log_q.size(), 0);

      // Premature marker as 7th byte
      clear_log();
      cyc(1'b1, 9'h101, 1'b0);
      cyc(1'b1, 9'h002, 1'b0);
      cyc(1'b1, 9'h003, 1'b0);
      cyc(1'b1, 9'h004, 1'b0);
      cyc(1'b1, 9'h005, 1'b0);
      cyc(1'b1, 9'h006, 1'b0);
      cyc(1'b1, 9'h1C3, 1'b0);
      cyc(1'b1, 9'h03C, 1'b0);
      idle(4);
      chk("sync_serr", serr_cnt, 1);
      chk("sync_count", log_q.size(), 4);
      chk_px(0, 16'h0102, 15'd0, 1'b0);
      chk_px(1, 16'h0304, 15'd1, 1'b0);
      chk_px(2, 16'h0506, 15'd2, 1'b0);
      chk_px(3, 16'hC33C, 15'd0, 1'b0);

      // One-cycle reset mid-pixel
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b0);
      clear_log();
      cyc(1'b1, 9'h1AB, 1'b0);
      cyc(1'b1, 9'h0CD, 1'b0);
      cyc(1'b1, 9'h0EF, 1'b0);
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b0);
      #1;
      chk("mid_rst_valid", {31'h0, cam.px_valid}, 0);
      chk("mid_rst_data", {16'h0, cam.px_data}, 0);
      chk("mid_rst_state", {30'h0, dut.state_q}, {30'h0, ST_SEEK});
      cyc(1'b1, 9'h011, 1'b0);
      cyc(1'b1, 9'h022, 1'b0);
      cyc(1'b1, 9'h033, 1'b0);
      cyc(1'b1, 9'h144, 1'b0);
      cyc(1'b1, 9'h055, 1'b0);
      cyc(1'b1, 9'h066, 1'b0);
      cyc(1'b1, 9'h077, 1'b0);
      idle(4);
      chk("mid_rst_count", log_q.size(), 3);
      chk_px(0, 16'hABCD, 15'd0, 1'b0);
      chk_px(1, 16'h4455, 15'd0, 1'b0);
      chk_px(2, 16'h6677, 15'd1, 1'b0);
      chk("mid_rst_serr", serr_cnt, 0);

`ifdef CAM_ERRCNT_EN
      // Saturating error counter
      cyc(1'b0, 9'h0, 1'b1);
      cyc(1'b0, 9'h0, 1'b0);
      #1 chk("errcnt_reset", {24'h0, cam.err_count}, 0);
      clear_log();
      for (int i = 0; i < 301; i++) cyc(1'b1, 9'h100, 1'b0);
      idle(3);
      chk("errcnt_pulses", serr_cnt, 300);
      chk("errcnt_sat", {24'h0, cam.err_count}, 32'd255);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cam_pixel_reader.md
# cam_pixel_reader

Drains the camera capture FIFO byte stream and rebuilds RGB565 pixels from byte pairs. Also generates the frame-buffer write address for each pixel. It sits directly downstream of the capture FIFO and feeds the frame buffer / colour-classification path of the cube reader. Frame alignment relies on the start-of-frame marker the FIFO stores in bit 8 of each entry.

## Interface
Parameters:
- H_PIXELS, 160: pixels per line.
- V_LINES, 120: lines per frame.
- ADDR_W, 15: frame-buffer address width; must satisfy 2^ADDR_W ≥ H_PIXELS·V_LINES.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fifo_empty  in  1  capture FIFO empty flag.
- fifo_rd  out  1  FIFO pop request.
- fifo_dout  in  9  FIFO read data, valid the cycle after fifo_rd. Bit 8 is the SOF marker (first byte after vsync); bits 7:0 are the camera byte.
- px_valid  out  1  one-cycle write strobe to the frame buffer.
- px_data  out  16  RGB565 pixel: high byte first, then low byte.
- px_addr  out  ADDR_W  linear address, row·H_PIXELS + col.
- frame_done  out  1  one-cycle pulse with the last pixel of a frame.
- sync_err  out  1  one-cycle pulse on a premature SOF marker.

## Operation
- fifo_rd = !fifo_empty && !reset. This is combinational, so every available byte is popped.
- rd_q registers fifo_rd. fifo_dout is consumed only in cycles where rd_q = 1.
- States: SEEK, HI, LO.
  - SEEK: a consumed byte with bit 8 = 0 is discarded. A byte with bit 8 = 1 is latched as the high byte, address resets to 0, next state is LO.
  - HI: consumed byte latched as the high byte, then go to LO.
  - LO: consumed byte forms px_data = {hi, byte[7:0]}. px_valid pulses with the current address.
- After each pixel write:
  - Address advances by one.
  - If the written address was H_PIXELS·V_LINES−1: frame_done pulses in the same cycle as px_valid, the address clears, and the state goes to SEEK.
  - Otherwise the state goes to HI.
- Premature SOF: a byte with bit 8 = 1 consumed in HI or LO (not the first byte of a frame).
  - sync_err pulses.
  - Any partial pixel is dropped.
  - The byte becomes the new high byte, address resets to 0, next state is LO.
- Address arithmetic is unsigned ADDR_W bits. The address never exceeds H_PIXELS·V_LINES−1.
- Reset values: state SEEK, rd_q 0, address 0, px_valid 0, px_data 0, px_addr 0, frame_done 0, sync_err 0.
- Reset mid-frame: everything returns to the reset values at the next edge. Bytes popped but not yet consumed are discarded, and the next frame waits for SOF.

## Timing
- Throughput: one byte per cycle when the FIFO is non-empty; one pixel every 2 consumed bytes.
- Latency: px_valid/px_data/px_addr are registered. They assert one cycle after the LO byte appears on fifo_dout, which is two cycles after the fifo_rd that popped it.
- Gaps (fifo_empty high) freeze the state. There are no timeouts.
- frame_done and sync_err are never high for two consecutive cycles from the same event.
- Simultaneous premature SOF and last-pixel: impossible, because the last pixel is written from LO, which takes a non-SOF byte. A marker in LO always goes down the sync_err path.

## Configuration
- CAM_ERRCNT_EN: when defined, adds output err_count [7:0].
  - Saturating count of sync_err pulses.
  - Cleared only by reset.
  - Holds 255 once reached.
- When CAM_ERRCNT_EN is undefined, the port and counter are absent. All other behaviour is identical.

## Structure
- Shared package cam_pkg holds:
  - state encoding (SEEK/HI/LO);
  - RGB565 field widths (R 5, G 6, B 5);
  - SOF bit index (8);
  - FIFO entry width (9).
- One sub-module, pix_addr_gen, contains the address counter. It has clear, advance and a last-pixel flag output, parameterised by H_PIXELS, V_LINES and ADDR_W.

## Test plan
Bench parameters: H_PIXELS=4, V_LINES=2.
- Reset release with FIFO empty: fifo_rd 0; all outputs 0; state stays SEEK.
- Bytes 0x11, 0x22 (no marker), then SOF 0x1F8 followed by 0x00: first two bytes discarded. px_data 0xF800 at px_addr 0, two cycles after the pop of 0x00.
- Full frame of 16 bytes (first with marker) streamed with an empty gap of 3 cycles after byte 5: 8 px_valid pulses, addresses 0..7. frame_done high only with address 7, and all pixels are correct across the gap.
- Marker arriving as the 7th byte of a frame: sync_err pulses once; pixels 0..2 were written; the next pixel written is at address 0 with hi = that byte.
- Reset asserted for 1 cycle after byte 3 of a frame: no px_valid for the partial pixel. Non-marker bytes are ignored until the next SOF, after which addresses restart at 0.
- With CAM_ERRCNT_EN: 300 premature markers give err_count = 255.
